// File: rtl/draw_pkg.sv
// draw_pkg: shared types and screen constants for the draw scheduler.
// Provides line_cmd_t, sched_state_e and the default screen/queue sizes.
package draw_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic       color;
    } line_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR_START,
        CLEARING,
        LN_START,
        LINING
    } sched_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO of line commands, async active-high reset.
// Ports: clk, reset, push/wdata, pop/head, full, empty, count.
module cmd_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  line_cmd_t              wdata,
    input  logic                   pop,
    output line_cmd_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    line_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: sequences clear and line engines onto one framebuffer port.
// Ports: cmd_* queue input, clear_req, clr_*/ln_* engine links, fb_* write
// port, busy, lines_done, drop_cnt. Option: DRAW_SCHED_FRAME_SYNC_EN.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int FIFO_DEPTH = draw_pkg::FIFO_DEPTH,
    parameter int SCREEN_W   = draw_pkg::SCREEN_W,
    parameter int SCREEN_H   = draw_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_x1,
    input  logic [8:0]  cmd_y0,
    input  logic [8:0]  cmd_y1,
    input  logic        cmd_color,
    input  logic        clear_req,
    input  logic        frame_start,
    output logic        clr_start,
    input  logic [9:0]  clr_x,
    input  logic [8:0]  clr_y,
    input  logic        clr_color,
    input  logic        clr_valid,
    input  logic        clr_done,
    output logic        ln_start,
    output logic [9:0]  ln_x0,
    output logic [9:0]  ln_x1,
    output logic [8:0]  ln_y0,
    output logic [8:0]  ln_y1,
    output logic        ln_color,
    input  logic [9:0]  ln_x,
    input  logic [8:0]  ln_y,
    input  logic        ln_pix_color,
    input  logic        ln_valid,
    input  logic        ln_done,
    output logic [9:0]  fb_x,
    output logic [8:0]  fb_y,
    output logic        fb_color,
    output logic        fb_write,
    output logic        busy,
    output logic [15:0] lines_done,
    output logic [7:0]  drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_e  state;
    line_cmd_t     cmd_in;
    line_cmd_t     head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          clear_pending;
    logic          accept;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          clr_go;

`ifdef DRAW_SCHED_FRAME_SYNC_EN
    assign clr_go = frame_start;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign clr_go = 1'b1;
`endif

    assign cmd_in = '{x0: cmd_x0, y0: cmd_y0,
                      x1: cmd_x1, y1: cmd_y1,
                      color: cmd_color};

    assign cmd_ready = !full;
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = (32'(cmd_x0) < SCREEN_W) &&
                       (32'(cmd_x1) < SCREEN_W) &&
                       (32'(cmd_y0) < SCREEN_H) &&
                       (32'(cmd_y1) < SCREEN_H);
    // Off-screen commands still complete the handshake but are dropped.
    assign push = accept && in_range;
    assign pop  = (state == LN_START);
    assign busy = (state != IDLE) || (count != '0) || clear_pending;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (cmd_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        fb_x     = '0;
        fb_y     = '0;
        fb_color = 1'b0;
        fb_write = 1'b0;
        case (state)
            CLEARING: begin
                fb_x     = clr_x;
                fb_y     = clr_y;
                fb_color = clr_color;
                fb_write = clr_valid;
            end
            LINING: begin
                fb_x     = ln_x;
                fb_y     = ln_y;
                fb_color = ln_pix_color;
                fb_write = ln_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            clr_start     <= 1'b0;
            ln_start      <= 1'b0;
            ln_x0         <= '0;
            ln_x1         <= '0;
            ln_y0         <= '0;
            ln_y1         <= '0;
            ln_color      <= 1'b0;
            lines_done    <= '0;
            drop_cnt      <= '0;
        end else begin
            clr_start <= 1'b0;
            ln_start  <= 1'b0;
            if (accept && !in_range && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            // Requests during an active clear coalesce into it.
            if (clear_req && state != CLR_START && state != CLEARING) begin
                clear_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // A pending clear blocks queued lines until it runs.
                    if (clear_pending) begin
                        if (clr_go) begin
                            state     <= CLR_START;
                            clr_start <= 1'b1;
                        end
                    end else if (!empty) begin
                        state <= LN_START;
                    end
                end
                CLR_START: begin
                    clear_pending <= 1'b0;
                    state         <= CLEARING;
                end
                CLEARING: begin
                    if (clr_done) begin
                        state <= IDLE;
                    end
                end
                LN_START: begin
                    ln_x0    <= head.x0;
                    ln_y0    <= head.y0;
                    ln_x1    <= head.x1;
                    ln_y1    <= head.y1;
                    ln_color <= head.color;
                    ln_start <= 1'b1;
                    state    <= LINING;
                end
                LINING: begin
                    if (ln_done) begin
                        lines_done <= lines_done + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
